mos_wishbone_bist_master: RTL
=============================

// Module: mos_wishbone_bist_master
// PURPOSE
//  Wishbone classic initiator that self-tests the MOS 6502 decoder Wishbone register block.
//  For each opcode in [START_OP..END_OP] it does four transactions:
//    - write the opcode to INSTR (BASE+0x0)
//    - read DEC_LO (BASE+0x4), DEC_MID (BASE+0x8) and DEC_HI (BASE+0xC)
//  Each read word is folded into a 32-bit signature, which the bench compares against a golden value.
//  Sits beside the management-core bus on the same slave port; used for on-chip BIST and bring-up.
// PARAMETERS
//  BASE_ADDR       32'h3000_0000  base address of the decoder register block
//  START_OP        8'h00          first opcode swept
//  END_OP          8'hFF          last opcode swept (must be >= START_OP)
//  SIG_SEED        32'hFFFF_FFFF  signature value loaded on start
//  TIMEOUT_CYCLES  16             ack wait limit in cycles (only with MOS_WB_TIMEOUT_EN)
// PORTS
//  wb_clk_i     in   1   clock
//  wb_rst_i     in   1   reset, asynchronous, active-high
//  start_i      in   1   one-cycle pulse: begin sweep (ignored while busy_o)
//  wbm_cyc_o    out  1   bus cycle
//  wbm_stb_o    out  1   strobe
//  wbm_we_o     out  1   1 = write
//  wbm_sel_o    out  4   byte selects, always 4'hF while stb
//  wbm_adr_o    out  32  address
//  wbm_dat_o    out  32  write data = {24'h0, opcode}
//  wbm_dat_i    in   32  read data from slave
//  wbm_ack_i    in   1   slave acknowledge
//  busy_o       out  1   sweep in progress
//  done_o       out  1   sweep finished; sticky until next accepted start_i
//  err_o        out  1   ack timeout occurred; sticky until next start
//  cur_op_o     out  8   opcode currently under test
//  signature_o  out  32  running / final signature
// BEHAVIOUR
//  Reset (async): all outputs 0, except signature_o = SIG_SEED and cur_op_o = START_OP. FSM -> IDLE.
//  FSM states: IDLE, ISSUE, GAP, DONE. Word index widx 0..3 (0 = write INSTR, 1..3 = reads LO/MID/HI).
//  IDLE:
//    - on start_i: signature <= SIG_SEED, cur_op <= START_OP, widx <= 0, clear done/err, busy=1
//    - go to ISSUE
//  ISSUE:
//    - cyc/stb=1; adr = BASE_ADDR + 4*widx; we = (widx==0)
//    - adr/dat/we held stable until ack
//  ISSUE, on ack_i=1 (sampled at posedge):
//    - cyc/stb deassert next cycle
//    - if widx!=0: sig <= {sig[30:0],sig[31]} ^ wbm_dat_i
//    - go to GAP
//  GAP: exactly one idle cycle (stb=0) so a level-held ack cannot be reused. Then:
//    - widx<3: widx++, go to ISSUE
//    - widx==3 and cur_op<END_OP: cur_op++, widx=0, go to ISSUE
//    - widx==3 and cur_op==END_OP: go to DONE
//  DONE: busy=0, done_o=1, return to IDLE the same cycle; done_o stays asserted.
//  Latency: with a registered-ack slave, 3 cycles/transaction.
//    - Full 256-opcode sweep = 1024 transactions = 3072 cycles, plus 1 start cycle.
//  Ack in GAP or IDLE: ignored. start_i while busy: ignored. cur_op is 8-bit; END_OP=FF never wraps to 00.
//  Reset mid-transaction: cyc/stb drop immediately (async); the sweep is lost and restarts only on a new start_i.
// CONFIGURATION
//  MOS_WB_TIMEOUT_EN defined:
//    - counter counts ISSUE cycles without ack; reaching TIMEOUT_CYCLES drops cyc/stb and sets err_o=1
//    - go to DONE (done_o=1, signature frozen)
//  MOS_WB_TIMEOUT_EN undefined:
//    - master waits indefinitely in ISSUE; err_o tied 0; no counter logic
// STRUCTURE
//  Package mos_wb_pkg:
//    - register offsets (INSTR 0x0, DEC_LO 0x4, DEC_MID 0x8, DEC_HI 0xC)
//    - FSM state encoding, widx width, signature fold function
//  Sub-module mos_wb_signature:
//    - 32-bit rotate-XOR accumulator with load(seed) and enable(data) ports
//  Top holds the FSM, opcode/widx counters and the timeout counter.
// TESTING (bench uses behavioural slave: registered ack, programmable delay, golden decoder model)
//  1 START_OP=END_OP=00, slave returns 0:
//    -> 4 transactions: W 3000_0000 d=0, then R ...04, ...08, ...0C; signature_o=FFFF_FFFF; done_o=1
//  2 Slave ack delayed 5 cycles:
//    -> cyc/stb/adr/we stable 6 cycles per transaction; one stb-low cycle between transactions
//  3 Full sweep 00..FF with golden decoder:
//    -> exactly 1024 acks; signature_o == bench-computed fold; done_o at cycle 3073 after start
//  4 MOS_WB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks:
//    -> stb high 16 cycles then low; err_o=1, done_o=1, busy_o=0
//  5 wb_rst_i pulsed during ISSUE of op 0x10:
//    -> cyc/stb=0 same cycle; signature_o=SIG_SEED; no further bus activity until start_i
//  6 start_i pulsed while busy, then again after done:
//    -> first ignored; second clears done_o, reloads seed, restarts at START_OP

Source files
------------

// File: rtl/mos_wb_pkg.sv
// Shared definitions for the MOS 6502 decoder BIST master: register map, FSM encoding, signature fold.
package mos_wb_pkg;

    localparam logic [31:0] OFS_INSTR   = 32'h0;
    localparam logic [31:0] OFS_DEC_LO  = 32'h4;
    localparam logic [31:0] OFS_DEC_MID = 32'h8;
    localparam logic [31:0] OFS_DEC_HI  = 32'hC;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int WIDX_W = 2;
    typedef logic [WIDX_W-1:0] widx_t;
    localparam widx_t WIDX_WRITE = 2'd0;
    localparam widx_t WIDX_LAST  = 2'd3;

    function automatic logic [31:0] reg_offset(input widx_t widx);
        case (widx)
            2'd0:    return OFS_INSTR;
            2'd1:    return OFS_DEC_LO;
            2'd2:    return OFS_DEC_MID;
            default: return OFS_DEC_HI;
        endcase
    endfunction

    function automatic logic [31:0] sig_fold(input logic [31:0] sig, input logic [31:0] dat);
        return {sig[30:0], sig[31]} ^ dat;
    endfunction

endpackage

// File: rtl/mos_wb_signature.sv
// Purpose: 32-bit rotate-XOR signature accumulator with seed load.
// Latency: result visible the cycle after load/en.
// Backpressure: none; load has priority over en.
module mos_wb_signature
    import mos_wb_pkg::*;
#(
    parameter logic [31:0] RST_VAL = 32'hFFFF_FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        en,
    input  logic [31:0] dat,
    output logic [31:0] sig
);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            sig <= RST_VAL;
        else if (load)
            sig <= seed;
        else if (en)
            sig <= sig_fold(sig, dat);
    end

endmodule

// File: rtl/mos_wishbone_bist_master.sv
// Purpose: Wishbone classic BIST master sweeping opcodes through the decoder block (MOS_WB_TIMEOUT_EN adds ack timeout).
// Latency: 3 cycles per transaction against a registered-ack slave, plus 1 cycle to accept start.
// Backpressure: each request is held until ack; one stb-low gap cycle separates transactions.
module mos_wishbone_bist_master
    import mos_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter logic [7:0]  START_OP       = 8'h00,
    parameter logic [7:0]  END_OP         = 8'hFF,
    parameter logic [31:0] SIG_SEED       = 32'hFFFF_FFFF,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [7:0]  cur_op_o,
    output logic [31:0] signature_o
);

    logic [1:0] state;
    widx_t      widx;
    logic [7:0] cur_op;
    logic       busy;
    logic       done;
    logic       issue;
    logic       sweep_go;
    logic       fold_en;
    logic       tmo_hit;

    assign issue    = (state == ST_ISSUE);
    assign sweep_go = start_i && ((state == ST_IDLE) || (state == ST_DONE));
    assign fold_en  = issue && wbm_ack_i && (widx != WIDX_WRITE);

`ifdef MOS_WB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             err;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            tmo_cnt <= '0;
        else if (issue && !wbm_ack_i)
            tmo_cnt <= tmo_cnt + 1'b1;
        else
            tmo_cnt <= '0;
    end

    assign tmo_hit = issue && !wbm_ack_i && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            err <= 1'b0;
        else if (sweep_go)
            err <= 1'b0;
        else if (tmo_hit)
            err <= 1'b1;
    end

    assign err_o = err;
`else
    localparam int tmo_cycles_unused = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state  <= ST_IDLE;
            widx   <= '0;
            cur_op <= START_OP;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_ISSUE: begin
                    if (wbm_ack_i) begin
                        state <= ST_GAP;
                    end else if (tmo_hit) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                // The gap cycle keeps a still-high ack from completing the next request.
                ST_GAP: begin
                    if (widx != WIDX_LAST) begin
                        widx  <= widx + 1'b1;
                        state <= ST_ISSUE;
                    end else if (cur_op < END_OP) begin
                        cur_op <= cur_op + 8'd1;
                        widx   <= '0;
                        state  <= ST_ISSUE;
                    end else begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    if (start_i) begin
                        state  <= ST_ISSUE;
                        widx   <= '0;
                        cur_op <= START_OP;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                    end
                end
            endcase
        end
    end

    mos_wb_signature #(
        .RST_VAL (SIG_SEED)
    ) u_sig (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .load     (sweep_go),
        .seed     (SIG_SEED),
        .en       (fold_en),
        .dat      (wbm_dat_i),
        .sig      (signature_o)
    );

    assign wbm_cyc_o = issue;
    assign wbm_stb_o = issue;
    assign wbm_we_o  = issue && (widx == WIDX_WRITE);
    assign wbm_sel_o = issue ? 4'hF : 4'h0;
    assign wbm_adr_o = issue ? (BASE_ADDR + reg_offset(widx)) : 32'h0;
    assign wbm_dat_o = wbm_we_o ? {24'h0, cur_op} : 32'h0;
    assign busy_o    = busy;
    assign done_o    = done;
    assign cur_op_o  = cur_op;

endmodule
